// File: rtl/bt656_pkg.sv
// Shared BT.656 definitions: preamble FSM states, preamble bytes, XY bit layout and protection bits.
package bt656_pkg;

    typedef enum logic [1:0] {
        S_SCAN = 2'd0,
        S_Z1   = 2'd1,
        S_Z2   = 2'd2,
        S_XY   = 2'd3
    } preambleState_t;

    localparam logic [7:0] PREAMBLE_FF = 8'hFF;
    localparam logic [7:0] PREAMBLE_00 = 8'h00;

    localparam int XY_BIT_ONE = 7;
    localparam int XY_BIT_F   = 6;
    localparam int XY_BIT_V   = 5;
    localparam int XY_BIT_H   = 4;

    // Protection nibble {P3,P2,P1,P0} as placed in XY bits 3..0.
    function automatic logic [3:0] bt656Prot(input logic f, input logic v, input logic h);
        bt656Prot = {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

endpackage

// File: rtl/bt656_rx_if.sv
// Input byte stream and decoded outputs of bt656_rx; the receiver uses the slave view.
interface bt656_rx_if #(
    parameter int CNT_WIDTH = 16
);
    logic [7:0]           i_Data;
    logic                 i_DataValid;
    logic [7:0]           o_Data;
    logic                 o_DataValid;
    logic                 o_Fsignal;
    logic                 o_Vsignal;
    logic                 o_Hsignal;
    logic                 o_Sav;
    logic                 o_Eav;
    logic                 o_ProtErr;
    logic [CNT_WIDTH-1:0] o_PixelCount;
    logic [CNT_WIDTH-1:0] o_LineCount;
    logic                 o_Locked;

    modport master (
        output i_Data, i_DataValid,
        input  o_Data, o_DataValid, o_Fsignal, o_Vsignal, o_Hsignal, o_Sav, o_Eav,
               o_ProtErr, o_PixelCount, o_LineCount, o_Locked
    );

    modport slave (
        input  i_Data, i_DataValid,
        output o_Data, o_DataValid, o_Fsignal, o_Vsignal, o_Hsignal, o_Sav, o_Eav,
               o_ProtErr, o_PixelCount, o_LineCount, o_Locked
    );
endinterface

// File: rtl/bt656_xy_decode.sv
// Combinational XY check; with BT656_RX_PROT_CORRECT_EN defined, single-bit errors in bits 6..0 are repaired.
module bt656_xy_decode
    import bt656_pkg::*;
(
    input  logic [7:0] xy,
    output logic       f,
    output logic       v,
    output logic       h,
    output logic       ok,
    output logic       corrected
);
    logic [3:0] syndrome_s;

    // Syndrome patterns: one-hot = a parity bit flipped, 0111/1011/1101 = F/V/H flipped.
    always_comb begin
        syndrome_s = xy[3:0] ^ bt656Prot(xy[XY_BIT_F], xy[XY_BIT_V], xy[XY_BIT_H]);
        f          = xy[XY_BIT_F];
        v          = xy[XY_BIT_V];
        h          = xy[XY_BIT_H];
        ok         = xy[XY_BIT_ONE] && (syndrome_s == 4'b0000);
        corrected  = 1'b0;
`ifdef BT656_RX_PROT_CORRECT_EN
        case (syndrome_s)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: corrected = xy[XY_BIT_ONE];
            4'b0111: begin
                f         = ~xy[XY_BIT_F];
                corrected = xy[XY_BIT_ONE];
            end
            4'b1011: begin
                v         = ~xy[XY_BIT_V];
                corrected = xy[XY_BIT_ONE];
            end
            4'b1101: begin
                h         = ~xy[XY_BIT_H];
                corrected = xy[XY_BIT_ONE];
            end
            default: corrected = 1'b0;
        endcase
`endif
    end
endmodule

// File: rtl/bt656_rx.sv
// BT.656 receiver: preamble tracking, timing-code decode, active-video extraction, counters and lock.
// Optional XY error correction is enabled by defining BT656_RX_PROT_CORRECT_EN.
module bt656_rx
    import bt656_pkg::*;
#(
    parameter int MAX_LINE_BYTES = 4096,
    parameter int LOCK_CODES     = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic      i_SysClock,
    input  logic      i_Reset,
    bt656_rx_if.slave bus
);
    localparam int TO_W = $clog2(MAX_LINE_BYTES + 1);
    localparam int LK_W = $clog2(LOCK_CODES + 1);

    preambleState_t       state_r, stateNext_s;
    logic                 active_r;
    logic [TO_W-1:0]      timeout_r;
    logic [LK_W-1:0]      lockCnt_r;
    logic                 prevEavV_r;
    logic [7:0]           data_r;
    logic                 dataValid_r, f_r, v_r, h_r, sav_r, eav_r, protErr_r, locked_r;
    logic [CNT_WIDTH-1:0] pixelCount_r, lineCount_r;

    logic decF_s, decV_s, decH_s, decOk_s, decCorrected_s;
    logic byteIsFf_s, byteIs00_s, xyByte_s, cleanCode_s, badCode_s, timeoutHit_s, emit_s;

    bt656_xy_decode u_xyDecode (
        .xy        (bus.i_Data),
        .f         (decF_s),
        .v         (decV_s),
        .h         (decH_s),
        .ok        (decOk_s),
        .corrected (decCorrected_s)
    );

    // Preamble state register.
    always_ff @(posedge i_SysClock) begin
        if (i_Reset) state_r <= S_SCAN;
        else         state_r <= stateNext_s;
    end

    // Preamble next state; an FF seen while expecting XY is decoded, not treated as a new preamble.
    always_comb begin
        stateNext_s = state_r;
        if (bus.i_DataValid) begin
            case (state_r)
                S_SCAN:  stateNext_s = byteIsFf_s ? S_Z1 : S_SCAN;
                S_Z1:    stateNext_s = byteIs00_s ? S_Z2 : (byteIsFf_s ? S_Z1 : S_SCAN);
                S_Z2:    stateNext_s = byteIs00_s ? S_XY : (byteIsFf_s ? S_Z1 : S_SCAN);
                S_XY:    stateNext_s = S_SCAN;
                default: stateNext_s = S_SCAN;
            endcase
        end else begin
            stateNext_s = state_r;
        end
    end

    // Per-byte events; the byte that trips the timeout is already outside the active region.
    always_comb begin
        byteIsFf_s   = (bus.i_Data == PREAMBLE_FF);
        byteIs00_s   = (bus.i_Data == PREAMBLE_00);
        xyByte_s     = bus.i_DataValid && (state_r == S_XY);
        cleanCode_s  = xyByte_s && (decOk_s || decCorrected_s);
        badCode_s    = xyByte_s && !(decOk_s || decCorrected_s);
        timeoutHit_s = bus.i_DataValid && !cleanCode_s && (timeout_r == TO_W'(MAX_LINE_BYTES - 1));
        emit_s       = bus.i_DataValid && active_r && !byteIsFf_s && !byteIs00_s && !timeoutHit_s;
    end

    // Datapath, flags, counters and lock tracking.
    always_ff @(posedge i_SysClock) begin
        if (i_Reset) begin
            active_r     <= 1'b0;
            timeout_r    <= '0;
            lockCnt_r    <= '0;
            prevEavV_r   <= 1'b0;
            data_r       <= 8'h00;
            dataValid_r  <= 1'b0;
            f_r          <= 1'b0;
            v_r          <= 1'b0;
            h_r          <= 1'b0;
            sav_r        <= 1'b0;
            eav_r        <= 1'b0;
            protErr_r    <= 1'b0;
            locked_r     <= 1'b0;
            pixelCount_r <= '0;
            lineCount_r  <= '0;
        end else begin
            dataValid_r <= emit_s;
            sav_r       <= cleanCode_s && !decH_s;
            eav_r       <= cleanCode_s && decH_s;
            protErr_r   <= badCode_s;
            if (emit_s) data_r <= bus.i_Data;

            if (cleanCode_s && !decH_s)  pixelCount_r <= '0;
            else if (emit_s)             pixelCount_r <= pixelCount_r + CNT_WIDTH'(1);

            if (cleanCode_s && !decH_s && !decV_s)                  active_r <= 1'b1;
            else if (bus.i_DataValid && (byteIsFf_s || timeoutHit_s)) active_r <= 1'b0;

            if (cleanCode_s) begin
                f_r <= decF_s;
                v_r <= decV_s;
                h_r <= decH_s;
                if (decF_s != f_r)             lineCount_r <= '0;
                else if (decH_s && !decV_s)    lineCount_r <= lineCount_r + CNT_WIDTH'(1);
                else if (decH_s && !prevEavV_r) lineCount_r <= '0;
                if (decH_s) prevEavV_r <= decV_s;
            end

            if (cleanCode_s)                                     timeout_r <= '0;
            else if (bus.i_DataValid && timeout_r != TO_W'(MAX_LINE_BYTES)) timeout_r <= timeout_r + TO_W'(1);

            if (badCode_s || timeoutHit_s) begin
                lockCnt_r <= '0;
                locked_r  <= 1'b0;
            end else if (cleanCode_s) begin
                if (lockCnt_r != LK_W'(LOCK_CODES))     lockCnt_r <= lockCnt_r + LK_W'(1);
                if (lockCnt_r >= LK_W'(LOCK_CODES - 1)) locked_r  <= 1'b1;
            end
        end
    end

    assign bus.o_Data       = data_r;
    assign bus.o_DataValid  = dataValid_r;
    assign bus.o_Fsignal    = f_r;
    assign bus.o_Vsignal    = v_r;
    assign bus.o_Hsignal    = h_r;
    assign bus.o_Sav        = sav_r;
    assign bus.o_Eav        = eav_r;
    assign bus.o_ProtErr    = protErr_r;
    assign bus.o_PixelCount = pixelCount_r;
    assign bus.o_LineCount  = lineCount_r;
    assign bus.o_Locked     = locked_r;
endmodule

// File: tb/tb_bt656_rx.sv
// Directed-plus-random bench for bt656_rx, checked every cycle against a byte-history reference model.
module tb_bt656_rx;
    localparam int MAXB  = 4096;
    localparam int LOCKN = 4;
    localparam int CW    = 16;

    logic clk;
    logic rstS;

    bt656_rx_if #(.CNT_WIDTH(CW)) bus();

    bt656_rx #(.MAX_LINE_BYTES(MAXB), .LOCK_CODES(LOCKN), .CNT_WIDTH(CW)) dut (
        .i_SysClock (clk),
        .i_Reset    (rstS),
        .bus        (bus)
    );

    int nCmp = 0;
    int nBad = 0;
    int dvCount = 0;

    // Reference model state: recent bytes, decoded flags, counters and expected pulses.
    logic [7:0]    hist [3];
    int            hLen, mTo, mLockCnt;
    logic          mActive, mF, mV, mH, mPrevEavV, mLocked;
    logic [CW-1:0] mPix, mLine;
    logic [7:0]    mData;
    logic          eValid, eSav, eEav, eErr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nBad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic parityOk(input logic [7:0] x);
        return (x[3] == (x[5] ^ x[4])) && (x[2] == (x[6] ^ x[4])) &&
               (x[1] == (x[6] ^ x[5])) && (x[0] == (x[6] ^ x[5] ^ x[4]));
    endfunction

    task automatic modelReset();
        hLen = 0; mTo = 0; mLockCnt = 0;
        mActive = 1'b0; mF = 1'b0; mV = 1'b0; mH = 1'b0; mPrevEavV = 1'b0; mLocked = 1'b0;
        mPix = '0; mLine = '0; mData = 8'h00;
        eValid = 1'b0; eSav = 1'b0; eEav = 1'b0; eErr = 1'b0;
    endtask

    task automatic modelStep(input logic [7:0] b, input logic vld);
        logic isCode, good, toHit, emit, f, v, h;
        logic [7:0] fixed, mask;
        eValid = 1'b0; eSav = 1'b0; eEav = 1'b0; eErr = 1'b0;
        if (!vld) return;
        isCode = (hLen == 3) && (hist[0] == 8'hFF) && (hist[1] == 8'h00) && (hist[2] == 8'h00);
        good = 1'b0;
        fixed = b;
        if (isCode) begin
            hLen = 0;
            if (b[7] && parityOk(b)) good = 1'b1;
`ifdef BT656_RX_PROT_CORRECT_EN
            else if (b[7]) begin
                for (int i = 0; i < 7; i++) begin
                    mask = 8'h01 << i;
                    if (parityOk(b ^ mask)) begin
                        good = 1'b1;
                        fixed = b ^ mask;
                    end
                end
            end
`endif
        end else begin
            hist[0] = hist[1]; hist[1] = hist[2]; hist[2] = b;
            if (hLen < 3) hLen++;
        end
        toHit = 1'b0;
        if (isCode && good) mTo = 0;
        else if (mTo < MAXB) begin
            mTo++;
            toHit = (mTo == MAXB);
        end
        emit = mActive && (b != 8'hFF) && (b != 8'h00) && !toHit;
        if (emit) begin
            eValid = 1'b1;
            mData = b;
            mPix++;
        end
        if (isCode && good) begin
            f = fixed[6]; v = fixed[5]; h = fixed[4];
            if (f != mF) mLine = '0;
            else if (h && !v) mLine++;
            else if (h && v && !mPrevEavV) mLine = '0;
            if (h) mPrevEavV = v;
            if (!h) begin
                eSav = 1'b1;
                mPix = '0;
                if (!v) mActive = 1'b1;
            end else eEav = 1'b1;
            mF = f; mV = v; mH = h;
            if (mLockCnt < LOCKN) mLockCnt++;
            if (mLockCnt == LOCKN) mLocked = 1'b1;
        end else if (isCode) begin
            eErr = 1'b1;
            mLockCnt = 0;
            mLocked = 1'b0;
        end
        if (b == 8'hFF) mActive = 1'b0;
        if (toHit) begin
            mActive = 1'b0;
            mLockCnt = 0;
            mLocked = 1'b0;
        end
    endtask

    task automatic checkAll();
        check("data",      32'(bus.o_Data),       32'(mData));
        check("dvalid",    32'(bus.o_DataValid),  32'(eValid));
        check("fsig",      32'(bus.o_Fsignal),    32'(mF));
        check("vsig",      32'(bus.o_Vsignal),    32'(mV));
        check("hsig",      32'(bus.o_Hsignal),    32'(mH));
        check("sav",       32'(bus.o_Sav),        32'(eSav));
        check("eav",       32'(bus.o_Eav),        32'(eEav));
        check("proterr",   32'(bus.o_ProtErr),    32'(eErr));
        check("pixcount",  32'(bus.o_PixelCount), 32'(mPix));
        check("linecount", 32'(bus.o_LineCount),  32'(mLine));
        check("locked",    32'(bus.o_Locked),     32'(mLocked));
    endtask

    task automatic step(input logic [7:0] b, input logic vld, input logic rst);
        @(negedge clk);
        bus.i_Data = b;
        bus.i_DataValid = vld;
        rstS = rst;
        if (rst) modelReset();
        else modelStep(b, vld);
        @(posedge clk);
        #1;
        if (bus.o_DataValid) dvCount++;
        checkAll();
    endtask

    task automatic sendByte(input logic [7:0] b, input logic gap);
        if (gap) step(8'($urandom), 1'b0, 1'b0);
        step(b, 1'b1, 1'b0);
    endtask

    task automatic sendCode(input logic f, input logic v, input logic h, input logic gap);
        logic [7:0] xy;
        xy = {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
        sendByte(8'hFF, gap);
        sendByte(8'h00, gap);
        sendByte(8'h00, gap);
        sendByte(xy, gap);
    endtask

    task automatic sendLine(input logic f, input int nAct, input logic gap);
        sendCode(f, 1'b0, 1'b0, gap);
        dvCount = 0;
        for (int i = 0; i < nAct; i++) sendByte(8'($urandom_range(1, 254)), gap);
        check("line_bytes", 32'(dvCount), 32'(nAct));
        sendCode(f, 1'b0, 1'b1, gap);
        check("pix_at_eav", 32'(bus.o_PixelCount), 32'(nAct));
        for (int i = 0; i < 8; i++) sendByte((i % 2 == 0) ? 8'h80 : 8'h10, gap);
    endtask

    initial begin
        rstS = 1'b1;
        bus.i_Data = 8'h00;
        bus.i_DataValid = 1'b0;
        modelReset();

        // Reset, including a valid FF arriving together with reset.
        step(8'h00, 1'b0, 1'b1);
        step(8'hFF, 1'b1, 1'b1);
        check("rst_locked", 32'(bus.o_Locked), 32'd0);
        check("rst_pix", 32'(bus.o_PixelCount), 32'd0);

        // Lock after four clean codes.
        sendCode(1'b0, 1'b1, 1'b0, 1'b0);
        sendCode(1'b0, 1'b1, 1'b1, 1'b0);
        sendCode(1'b0, 1'b1, 1'b0, 1'b0);
        check("lock_after_3", 32'(bus.o_Locked), 32'd0);
        sendCode(1'b0, 1'b1, 1'b1, 1'b0);
        check("lock_after_4", 32'(bus.o_Locked), 32'd1);

        // FF FF 00 00 80 then Cb=0x10.
        sendByte(8'hFF, 1'b0); sendByte(8'hFF, 1'b0); sendByte(8'h00, 1'b0);
        sendByte(8'h00, 1'b0); sendByte(8'h80, 1'b0);
        check("dir_sav", 32'(bus.o_Sav), 32'd1);
        check("dir_v", 32'(bus.o_Vsignal), 32'd0);
        sendByte(8'h10, 1'b0);
        check("dir_dv", 32'(bus.o_DataValid), 32'd1);
        check("dir_data", 32'(bus.o_Data), 32'h10);

        // Field of 288 active lines: full-width lines (one with gapped valid), then short lines.
        sendLine(1'b0, 1440, 1'b0);
        sendLine(1'b0, 1440, 1'b1);
        sendLine(1'b0, 1440, 1'b0);
        for (int i = 0; i < 285; i++) sendLine(1'b0, $urandom_range(1, 32), 1'b0);
        check("lines_288", 32'(bus.o_LineCount), 32'd288);
        sendCode(1'b0, 1'b1, 1'b1, 1'b0);
        check("lines_blank_clr", 32'(bus.o_LineCount), 32'd0);

        // F toggle clears the line counter.
        sendLine(1'b0, 4, 1'b0);
        sendLine(1'b0, 4, 1'b0);
        check("lines_2", 32'(bus.o_LineCount), 32'd2);
        sendCode(1'b1, 1'b0, 1'b0, 1'b0);
        check("ftoggle_f", 32'(bus.o_Fsignal), 32'd1);
        check("ftoggle_clr", 32'(bus.o_LineCount), 32'd0);

        // Clean EAV 0x9D, then the same code with P0 flipped (0x9C).
        sendByte(8'hFF, 1'b0); sendByte(8'h00, 1'b0); sendByte(8'h00, 1'b0); sendByte(8'h9D, 1'b0);
        check("eav_9d", 32'(bus.o_Eav), 32'd1);
        sendByte(8'hFF, 1'b0); sendByte(8'h00, 1'b0); sendByte(8'h00, 1'b0); sendByte(8'h9C, 1'b0);
`ifdef BT656_RX_PROT_CORRECT_EN
        check("flip_eav", 32'(bus.o_Eav), 32'd1);
        check("flip_noerr", 32'(bus.o_ProtErr), 32'd0);
`else
        check("flip_err", 32'(bus.o_ProtErr), 32'd1);
        check("flip_unlock", 32'(bus.o_Locked), 32'd0);
`endif

        // Timeout: relock, enter active video, then 4096 bytes with no code.
        sendCode(1'b0, 1'b1, 1'b0, 1'b0);
        sendCode(1'b0, 1'b1, 1'b1, 1'b0);
        sendCode(1'b0, 1'b1, 1'b0, 1'b0);
        sendCode(1'b0, 1'b0, 1'b0, 1'b0);
        check("to_locked", 32'(bus.o_Locked), 32'd1);
        for (int i = 0; i < MAXB - 1; i++) sendByte(8'h80, 1'b0);
        check("to_4095", 32'(bus.o_Locked), 32'd1);
        sendByte(8'h80, 1'b0);
        check("to_4096", 32'(bus.o_Locked), 32'd0);
        dvCount = 0;
        for (int i = 0; i < 4; i++) sendByte(8'h42, 1'b0);
        check("to_no_dv", 32'(dvCount), 32'd0);

        // Random byte soup rich in FF/00 and XY candidates, with random valid gaps.
        sendCode(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 9);
            if (r < 2)       b = 8'hFF;
            else if (r < 4)  b = 8'h00;
            else if (r == 4) b = 8'h80 | 8'($urandom);
            else             b = 8'($urandom);
            step(b, ($urandom_range(0, 3) != 0), 1'b0);
        end

        // Reset in the middle of an active line.
        sendCode(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) sendByte(8'($urandom_range(1, 254)), 1'b0);
        step(8'h55, 1'b1, 1'b1);
        check("midrst_dv", 32'(bus.o_DataValid), 32'd0);
        check("midrst_pix", 32'(bus.o_PixelCount), 32'd0);
        check("midrst_data", 32'(bus.o_Data), 32'd0);
        step(8'h66, 1'b1, 1'b0);
        check("midrst_nostale", 32'(bus.o_DataValid), 32'd0);
        sendCode(1'b0, 1'b0, 1'b0, 1'b0);
        check("midrst_sav_pix", 32'(bus.o_PixelCount), 32'd0);
        sendByte(8'h21, 1'b0);
        check("midrst_pix1", 32'(bus.o_PixelCount), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
